// File: rtl/ram_dump_uart_if.sv
// Handshake bundle between the dump engine and the top level: start request,
// RAM read port, status flags and the UART TX line.
interface ram_dump_uart_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [7:0]            ram_data;
  logic                  dump_active;
  logic [ADDR_WIDTH-1:0] dump_address;
  logic                  busy;
  logic                  done;
  logic                  tx;

  modport master (
    output start, ram_data,
    input  dump_active, dump_address, busy, done, tx
  );

  modport slave (
    input  start, ram_data,
    output dump_active, dump_address, busy, done, tx
  );
endinterface

// File: rtl/ram_dump_uart.sv
// Walks the program RAM and streams each byte as two uppercase hex characters
// over an 8N1 UART, terminating the dump with CR LF.
module ram_dump_uart #(
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16
) (
  input logic           clk,
  input logic           rst,
  ram_dump_uart_if.slave dump_if
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, LATCH, SEND_HI, SEND_LO, SEND_CR, SEND_LF, DONE
  } state_t;

  state_t                state_q;
  logic [7:0]            data_q;
  logic [7:0]            char_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [3:0]            bit_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  active_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tx_q;

  logic                  baud_end_d;
  logic                  tx_bit_d;
  logic [7:0]            next_char_d;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // bit_q counts the bit being driven (0 = start, 1..8 = data, 9 = stop)
  always_comb begin
    baud_end_d  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    tx_bit_d    = (bit_q < 4'd8) ? char_q[bit_q[2:0]] : 1'b1;
    next_char_d = 8'h0D;
    case (state_q)
      SEND_HI: next_char_d = hex(data_q[3:0]);
      SEND_LO: next_char_d = 8'h0D;
      SEND_CR: next_char_d = 8'h0A;
      default: next_char_d = 8'h0D;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= 8'h00;
      char_q   <= 8'h00;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      addr_q   <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          addr_q <= '0;
          if (dump_if.start) begin
            state_q  <= ADDR;
            active_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ADDR: state_q <= LATCH;
        LATCH: begin
          data_q  <= dump_if.ram_data;
          char_q  <= hex(dump_if.ram_data[7:4]);
          baud_q  <= '0;
          bit_q   <= 4'd0;
          tx_q    <= 1'b0;
          state_q <= SEND_HI;
        end
        SEND_HI, SEND_LO, SEND_CR, SEND_LF: begin
          if (!baud_end_d) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            if (bit_q != 4'd9) begin
              bit_q <= bit_q + 4'd1;
              tx_q  <= tx_bit_d;
            end else begin
              // Next character starts immediately so its start bit follows the stop bit
              bit_q  <= 4'd0;
              char_q <= next_char_d;
              tx_q   <= 1'b0;
              case (state_q)
                SEND_HI: state_q <= SEND_LO;
                SEND_LO: begin
                  if (addr_q < ADDR_WIDTH'(DEPTH - 1)) begin
                    addr_q  <= addr_q + 1'b1;
                    tx_q    <= 1'b1;
                    state_q <= ADDR;
                  end else begin
                    state_q <= SEND_CR;
                  end
                end
                SEND_CR: state_q <= SEND_LF;
                default: begin
                  tx_q     <= 1'b1;
                  done_q   <= 1'b1;
                  active_q <= 1'b0;
                  state_q  <= DONE;
                end
              endcase
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump_if.dump_active  = active_q;
  assign dump_if.dump_address = addr_q;
  assign dump_if.busy         = busy_q;
  assign dump_if.done         = done_q;
  assign dump_if.tx           = tx_q;

endmodule

// File: tb/tb_ram_dump_uart.sv
// Directed bench for ram_dump_uart: behavioural RAM, UART receiver model,
// table-driven character checks plus hand-written timing and reset sequences.
module tb_ram_dump_uart;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  logic [7:0] mem [DEPTH];

  ram_dump_uart_if #(.ADDR_WIDTH(AW)) bus ();

  ram_dump_uart #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .dump_if(bus.slave)
  );

  assign bus.ram_data = mem[bus.dump_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int busyCount = 0;
  int frameErr = 0;
  logic [7:0] rxQ[$];
  int addrQ[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] hiChar;
    logic [7:0] loChar;
  } vec_t;
  vec_t vecs [DEPTH];

  always @(negedge clk) begin
    if (bus.done === 1'b1) doneCount++;
    if (bus.busy === 1'b1) busyCount++;
  end

  // Receiver samples each bit in its second cycle, i.e. near mid-bit
  initial begin
    logic [7:0] b;
    int a;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        a = int'(bus.dump_address);
        @(negedge clk);
        if (bus.tx !== 1'b0) frameErr++;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        if (bus.tx !== 1'b1) frameErr++;
        rxQ.push_back(b);
        addrQ.push_back(a);
      end
    end
  end

  function automatic logic [7:0] getRx(input int idx);
    return (idx < rxQ.size()) ? rxQ[idx] : 8'hFF;
  endfunction

  function automatic int getAddr(input int idx);
    return (idx < addrQ.size()) ? addrQ[idx] : -1;
  endfunction

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic clearMonitors();
    @(posedge clk);
    rxQ.delete();
    addrQ.delete();
    doneCount = 0;
    busyCount = 0;
    frameErr  = 0;
  endtask

  task automatic waitDone(input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done timeout", 0, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " tx"}, 32'(bus.tx), 1);
    checkOutput({tag, " busy"}, 32'(bus.busy), 0);
    checkOutput({tag, " dump_active"}, 32'(bus.dump_active), 0);
    checkOutput({tag, " dump_address"}, 32'(bus.dump_address), 0);
    checkOutput({tag, " done"}, 32'(bus.done), 0);
  endtask

  initial begin
    logic [41:0] wave;
    bit waitOk;

    vecs[0]  = '{8'h00, 8'h30, 8'h30};
    vecs[1]  = '{8'h11, 8'h31, 8'h31};
    vecs[2]  = '{8'h22, 8'h32, 8'h32};
    vecs[3]  = '{8'h33, 8'h33, 8'h33};
    vecs[4]  = '{8'h44, 8'h34, 8'h34};
    vecs[5]  = '{8'h55, 8'h35, 8'h35};
    vecs[6]  = '{8'h66, 8'h36, 8'h36};
    vecs[7]  = '{8'h77, 8'h37, 8'h37};
    vecs[8]  = '{8'h88, 8'h38, 8'h38};
    vecs[9]  = '{8'h99, 8'h39, 8'h39};
    vecs[10] = '{8'hAA, 8'h41, 8'h41};
    vecs[11] = '{8'hBB, 8'h42, 8'h42};
    vecs[12] = '{8'hCC, 8'h43, 8'h43};
    vecs[13] = '{8'hDD, 8'h44, 8'h44};
    vecs[14] = '{8'hEE, 8'h45, 8'h45};
    vecs[15] = '{8'hFF, 8'h46, 8'h46};

    rst = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

    // Reset takes effect between clock edges
    #3 rst = 1'b1;
    #1 checkResetOutputs("reset immediate");
    repeat (5) @(negedge clk);
    checkResetOutputs("reset held");
    rst = 1'b0;

    $display("[TB] table-driven full dump");
    for (int i = 0; i < DEPTH; i++) mem[i] = vecs[i].data;
    clearMonitors();
    applyStimulus();
    waitDone(3000);
    repeat (2) @(negedge clk);
    checkOutput("char count", 32'(rxQ.size()), 34);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("hi char %0d", i), 32'(getRx(2 * i)), 32'(vecs[i].hiChar));
      checkOutput($sformatf("lo char %0d", i), 32'(getRx(2 * i + 1)), 32'(vecs[i].loChar));
    end
    checkOutput("CR", 32'(getRx(32)), 32'h0D);
    checkOutput("LF", 32'(getRx(33)), 32'h0A);
    checkOutput("done pulses", 32'(doneCount), 1);
    checkOutput("framing errors", 32'(frameErr), 0);
    checkOutput("address after done", 32'(bus.dump_address), 0);

    $display("[TB] first-character waveform");
    mem[0] = 8'h3C;
    // cycles N+1..N+42: ADDR, LATCH, start x4, '3' LSB first x4 each, stop x4
    wave = {{4{1'b1}}, {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b1}},
            {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b1}}, {4{1'b0}}, 2'b11};
    clearMonitors();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("N+1 dump_active", 32'(bus.dump_active), 1);
    checkOutput("N+1 dump_address", 32'(bus.dump_address), 0);
    checkOutput("N+1 busy", 32'(bus.busy), 1);
    checkOutput("wave 0", 32'(bus.tx), 32'(wave[0]));
    for (int c = 1; c < 42; c++) begin
      @(negedge clk);
      checkOutput($sformatf("wave %0d", c), 32'(bus.tx), 32'(wave[c]));
    end
    @(negedge clk);
    checkOutput("lo char start bit", 32'(bus.tx), 0);
    waitDone(3000);
    repeat (2) @(negedge clk);
    checkOutput("3C hi char", 32'(getRx(0)), 32'h33);
    checkOutput("3C lo char", 32'(getRx(1)), 32'h43);

    $display("[TB] start ignored while busy");
    mem[0] = 8'h00;
    clearMonitors();
    applyStimulus();
    repeat (100) @(negedge clk);
    applyStimulus();
    repeat (400) @(negedge clk);
    applyStimulus();
    repeat (400) @(negedge clk);
    applyStimulus();
    waitDone(3000);
    repeat (2) @(negedge clk);
    checkOutput("busy char count", 32'(rxQ.size()), 34);
    checkOutput("busy done pulses", 32'(doneCount), 1);
    // busy window counted from the cycle start is accepted through DONE
    checkOutput("busy window", 32'(busyCount + 1), 32'(16 * 82 + 80 + 2));
    checkOutput("busy last char", 32'(getRx(33)), 32'h0A);
    checkOutput("idle after dump", 32'(bus.busy), 0);

    $display("[TB] reset mid-character");
    clearMonitors();
    applyStimulus();
    waitOk = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.dump_address === 4'd7) begin
        waitOk = 1'b1;
        break;
      end
    end
    if (!waitOk) checkOutput("address 7 timeout", 0, 1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetOutputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkResetOutputs("after abort");
    clearMonitors();
    applyStimulus();
    waitDone(3000);
    repeat (2) @(negedge clk);
    checkOutput("restart char count", 32'(rxQ.size()), 34);
    checkOutput("restart first char", 32'(getRx(0)), 32'h30);
    checkOutput("restart first address", 32'(getAddr(0)), 0);
    checkOutput("restart 8th byte hi", 32'(getRx(14)), 32'h37);
    checkOutput("restart done pulses", 32'(doneCount), 1);
    checkOutput("restart framing", 32'(frameErr), 0);

    $display("[TB] single non-zero byte with start held");
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    mem[5] = 8'hAB;
    clearMonitors();
    @(negedge clk);
    bus.start = 1'b1;
    waitDone(3000);
    @(negedge clk);
    checkOutput("held start idle busy", 32'(bus.busy), 0);
    @(negedge clk);
    checkOutput("held start restart busy", 32'(bus.busy), 1);
    checkOutput("held start restart address", 32'(bus.dump_address), 0);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("AB char 11", 32'(getRx(10)), 32'h41);
    checkOutput("AB char 12", 32'(getRx(11)), 32'h42);
    checkOutput("AB char 11 address", 32'(getAddr(10)), 5);
    checkOutput("AB char 12 address", 32'(getAddr(11)), 5);
    checkOutput("byte 4 lo", 32'(getRx(9)), 32'h30);
    checkOutput("byte 6 hi", 32'(getRx(12)), 32'h30);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
